// File: rtl/rob_complete_arbiter_if.sv
// Completion bus between the execute-stage requesters, the arbiter and the
// ROB completion ports. The master side is the requester/ROB environment,
// the slave side is the arbiter.
interface rob_complete_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 3,
  parameter int ROB_SIZE  = 64,
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32
);
  localparam int IW = $clog2(ROB_SIZE);

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ*IW-1:0]          req_indx_i;
  logic [NUM_REQ*PC_SIZE-1:0]     req_pc_i;
  logic [NUM_REQ*WORD_SIZE-1:0]   req_val_i;
  logic [NUM_PORTS-1:0]           en_complete_o;
  logic [NUM_PORTS*IW-1:0]        complete_indx_o;
  logic [NUM_PORTS*PC_SIZE-1:0]   complete_pc_o;
  logic [NUM_PORTS*WORD_SIZE-1:0] complete_val_o;

  modport master (
    output req_valid_i, req_indx_i, req_pc_i, req_val_i,
    input  req_ready_o, en_complete_o, complete_indx_o, complete_pc_o, complete_val_o
  );

  modport slave (
    input  req_valid_i, req_indx_i, req_pc_i, req_val_i,
    output req_ready_o, en_complete_o, complete_indx_o, complete_pc_o, complete_val_o
  );
endinterface

// File: rtl/rob_complete_arbiter.sv
// Round-robin completion arbiter: grants up to NUM_PORTS of NUM_REQ
// functional-unit results per cycle and registers the winners onto the
// ROB completion ports (one cycle latency, ports filled densely from 0).
module rob_complete_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 3,
  parameter int ROB_SIZE  = 64,
  parameter int PC_SIZE   = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  rob_complete_if.slave              bus,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr_o,
  output logic                       err_dup_o
);
  localparam int IW = $clog2(ROB_SIZE);
  localparam int PW = $clog2(NUM_REQ);

  logic [IW-1:0]        req_indx [NUM_REQ];
  logic [PC_SIZE-1:0]   req_pc   [NUM_REQ];
  logic [WORD_SIZE-1:0] req_val  [NUM_REQ];

  logic [NUM_REQ-1:0]   ready;
  logic [NUM_PORTS-1:0] port_en;
  logic [PW-1:0]        port_sel [NUM_PORTS];
  logic [PW-1:0]        last_grant;
  logic [PW:0]          scan_sum;
  logic [PW-1:0]        scan_idx;
  logic                 placed;
  logic                 dup;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;

  logic [NUM_PORTS-1:0] vld_p1;
  logic [IW-1:0]        indx_p1 [NUM_PORTS];
  logic [PC_SIZE-1:0]   pc_p1   [NUM_PORTS];
  logic [WORD_SIZE-1:0] val_p1  [NUM_PORTS];
  logic                 err_dup;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign req_indx[r] = bus.req_indx_i[r*IW +: IW];
    assign req_pc[r]   = bus.req_pc_i[r*PC_SIZE +: PC_SIZE];
    assign req_val[r]  = bus.req_val_i[r*WORD_SIZE +: WORD_SIZE];
  end

  // Circular scan from rr_ptr; each grant takes the lowest free port.
  always_comb begin
    ready      = '0;
    port_en    = '0;
    last_grant = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    placed     = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) port_sel[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NUM_REQ)) scan_sum = scan_sum - (PW+1)'(NUM_REQ);
      scan_idx = scan_sum[PW-1:0];
      // Last port still free means there is room for another grant.
      if (bus.req_valid_i[scan_idx] && !port_en[NUM_PORTS-1] && !flush_i && rst_n_i) begin
        ready[scan_idx] = 1'b1;
        last_grant      = scan_idx;
        placed          = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!placed && !port_en[p]) begin
            port_en[p]  = 1'b1;
            port_sel[p] = scan_idx;
            placed      = 1'b1;
          end
        end
      end
    end
  end

  // Flag any pair of same-cycle grants targeting the same ROB entry.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (port_en[i] && port_en[j] && (req_indx[port_sel[i]] == req_indx[port_sel[j]]))
          dup = 1'b1;
      end
    end
  end

  // Next start pointer: one past the last winner, cleared by flush.
  always_comb begin
    rr_next = rr_ptr;
    if (flush_i)
      rr_next = '0;
    else if (|port_en)
      rr_next = (last_grant == PW'(NUM_REQ - 1)) ? '0 : last_grant + 1'b1;
  end

  // ---- stage p1: registered completion ports ----
  // Winners are captured into the port registers; unused ports hold payload.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1  <= '0;
      rr_ptr  <= '0;
      err_dup <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        indx_p1[p] <= '0;
        pc_p1[p]   <= '0;
        val_p1[p]  <= '0;
      end
    end else begin
      vld_p1 <= port_en;
      rr_ptr <= rr_next;
      if (dup) err_dup <= 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_en[p]) begin
          indx_p1[p] <= req_indx[port_sel[p]];
          pc_p1[p]   <= req_pc[port_sel[p]];
          val_p1[p]  <= req_val[port_sel[p]];
        end
      end
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.en_complete_o = vld_p1;
  assign rr_ptr_o          = rr_ptr;
  assign err_dup_o         = err_dup;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pack
    assign bus.complete_indx_o[p*IW +: IW]             = indx_p1[p];
    assign bus.complete_pc_o[p*PC_SIZE +: PC_SIZE]     = pc_p1[p];
    assign bus.complete_val_o[p*WORD_SIZE +: WORD_SIZE] = val_p1[p];
  end
endmodule

// File: doc/rob_complete_arbiter.md
Name: rob_complete_arbiter

Overview:
Arbitrates completion (writeback) requests from NUM_REQ functional units onto the reorder buffer's NUM_PORTS completion ports.
- Grants up to NUM_PORTS requests per cycle in round-robin order using a valid/ready handshake.
- Registers the winners so the ROB completion interface is driven directly from flops.
- Sits between the execute stage result buses and the ROB complete_* inputs. Supports a pipeline flush.

Parameters:
NUM_REQ, 4, number of functional-unit requesters (ALU0, ALU1, MEM, MUL); legal range 2..8
NUM_PORTS, 3, number of ROB completion ports; must satisfy 1 <= NUM_PORTS <= NUM_REQ
ROB_SIZE, 64, ROB entries; index width IW = $clog2(ROB_SIZE)
PC_SIZE, 32, PC width
WORD_SIZE, 32, result value width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline flush
req_valid_i  in  NUM_REQ  requester r holds a result
req_ready_o  out  NUM_REQ  requester r granted this cycle (combinational)
req_indx_i  in  NUM_REQ*IW  ROB index per requester, slice r at [r*IW +: IW]
req_pc_i  in  NUM_REQ*PC_SIZE  PC per requester
req_val_i  in  NUM_REQ*WORD_SIZE  result value per requester
en_complete_o  out  NUM_PORTS  completion port p valid
complete_indx_o  out  NUM_PORTS*IW  ROB index per port
complete_pc_o  out  NUM_PORTS*PC_SIZE  PC per port
complete_val_o  out  NUM_PORTS*WORD_SIZE  value per port
rr_ptr_o  out  $clog2(NUM_REQ)  current round-robin start pointer (debug)
err_dup_o  out  1  sticky: two same-cycle grants carried the same ROB index

Behaviour:
- Reset (rst_n_i=0, asynchronous): en_complete_o=0; complete_indx_o, complete_pc_o and complete_val_o all 0; rr_ptr=0; err_dup_o=0. req_ready_o=0 while reset is asserted.
- Handshake: a transfer occurs on a cycle where req_valid_i[r] && req_ready_o[r].
  - A requester holds valid and payload stable until it is accepted. Payload change while valid is a requester protocol violation and is not checked.
  - req_ready_o is never asserted for a requester whose valid is low.
- Selection (combinational):
  - Scan requesters in circular order rr_ptr, rr_ptr+1, ..., rr_ptr+NUM_REQ-1 (mod NUM_REQ).
  - Grant the first min(NUM_PORTS, count of valid) valid requesters.
  - The k-th grant in scan order is assigned to port k. Ports are filled densely from port 0 with no gaps.
- Latency: exactly 1 cycle. A request accepted in cycle N appears on its port with en_complete_o[k]=1 in cycle N+1. Ports without a grant in cycle N have en_complete_o[k]=0 in N+1.
- Output payload of an unused port holds its previous value. Only en_complete_o qualifies the payload.
- Pointer update: if at least one grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ; otherwise rr_ptr is unchanged. This bounds starvation to ceil(NUM_REQ/NUM_PORTS) cycles while the requester stays valid.
- Flush (flush_i=1, synchronous, overrides arbitration):
  - req_ready_o=0 in that cycle; no transfer occurs.
  - Next cycle: en_complete_o=0 and rr_ptr=0.
  - Results already registered on the ports in the flush cycle are still presented in that cycle; the ROB discards them.
  - err_dup_o is not cleared by flush.
- Duplicate check: if two or more grants in the same cycle carry equal req_indx_i, set err_dup_o=1 at the next edge. It stays set until reset. The grants still proceed unmodified.
- No backpressure from the ROB: completion ports are always accepted.
- No internal buffering beyond the output register.

Test Plan:
- Reset, then req_valid_i=4'b0001, indx0=5, pc0=0x100, val0=0xDEAD -> req_ready_o=4'b0001 same cycle; next cycle en_complete_o=3'b001, complete_indx[0]=5, pc=0x100, val=0xDEAD; rr_ptr_o=1.
- All 4 valid, rr_ptr=0 -> grants r0,r1,r2 on ports 0,1,2; r3 not ready; rr_ptr=3. Next cycle r3 (still valid) and r0,r1 granted, with r3 on port 0; rr_ptr=2.
- Fairness: all 4 valid continuously for 8 cycles -> each requester granted exactly 6 times; no requester waits more than 2 cycles.
- Flush in a cycle with 3 requesters valid -> req_ready_o=0 that cycle; next cycle en_complete_o=0 and rr_ptr_o=0; requests are granted normally the cycle after.
- r1 and r2 valid with equal indx=12 -> both granted; err_dup_o=1 next cycle and still 1 after 10 idle cycles and a flush.
- Assert rst_n_i low mid-cycle while en_complete_o=3'b111 -> outputs zero immediately without waiting for a clock edge; after release the first grant starts from r0.
